rgb_stream_unpacker: RTL and testbench

- Source-side block feeding the RGB-to-grayscale stage.
- Receives a byte-serial pixel stream (for example from a UART or memory reader) and assembles three consecutive bytes into one RGB pixel.
- Presents each pixel on parallel red/green/blue outputs with a one-cycle done_o strobe, which is the exact input protocol the grayscale stage consumes.
- Tracks column and row position and flags start-of-frame, end-of-line and end-of-frame.

---
 rtl/rgb_stream_unpacker.sv | 153 +++++++++++++++
 tb/tb_rgb_stream_unpacker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_unpacker.sv
// rgb_stream_unpacker
//   Assembles a byte-serial pixel stream into parallel RGB pixels for the
//   grayscale stage. Every three accepted bytes form one pixel. The pixel
//   is presented for exactly one cycle with a done_o strobe, together with
//   frame position flags.
//
//   Optional build macro: RGB_UNPACK_BGR_ORDER_EN
//     When it is defined, the byte order is blue, green, red (BMP storage
//     order). When it is undefined, the order is red, green, blue.
//
// Parameters
//   DATA_WIDTH  channel / byte width
//   IMG_WIDTH   pixels per line
//   IMG_HEIGHT  lines per frame
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   start_i             arms or re-arms frame reception (one-cycle pulse)
//   byte_i/byte_valid_i incoming channel byte and its qualifier
//   byte_ready_o        high while a byte can be accepted (RUN state)
//   red_o/green_o/blue_o assembled pixel; zero whenever done_o is low
//   done_o              one-cycle pixel strobe
//   sof_o/eol_o/eof_o   start-of-frame / end-of-line / end-of-frame flags
//   busy_o              high while in RUN
module rgb_stream_unpacker #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic [DATA_WIDTH-1:0] red_o,
    output logic [DATA_WIDTH-1:0] green_o,
    output logic [DATA_WIDTH-1:0] blue_o,
    output logic                  done_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic                  eof_o,
    output logic                  busy_o
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_nxt;
    logic [1:0]            phase;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] first_q;   // byte taken in phase 0 (red, or blue in BGR order)
    logic [DATA_WIDTH-1:0] green_q;

    logic accept, pix_done, last_col, last_row;

    // start_i takes priority over a byte in the same cycle, so that byte is dropped
    assign accept   = (state == RUN) && byte_valid_i && !start_i;
    assign pix_done = accept && (phase == 2'd2);
    assign last_col = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row == ROW_W'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = RUN;
            end
            RUN: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                // The last pixel of the frame drops back to IDLE on the same edge that emits it
                if (pix_done && last_col && last_row) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   <= 2'd0;
            col     <= '0;
            row     <= '0;
            first_q <= '0;
            green_q <= '0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
            done_o  <= 1'b0;
            sof_o   <= 1'b0;
            eol_o   <= 1'b0;
            eof_o   <= 1'b0;
        end else begin
            // Pixel outputs are zero except in the strobe cycle
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
            done_o  <= 1'b0;
            sof_o   <= 1'b0;
            eol_o   <= 1'b0;
            eof_o   <= 1'b0;

            if (start_i) begin
                phase <= 2'd0;
                col   <= '0;
                row   <= '0;
            end else if (accept) begin
                case (phase)
                    2'd0: begin
                        first_q <= byte_i;
                        phase   <= 2'd1;
                    end
                    2'd1: begin
                        green_q <= byte_i;
                        phase   <= 2'd2;
                    end
                    default: begin
                        phase   <= 2'd0;
                        done_o  <= 1'b1;
                        green_o <= green_q;
`ifdef RGB_UNPACK_BGR_ORDER_EN
                        blue_o  <= first_q;
                        red_o   <= byte_i;
`else
                        red_o   <= first_q;
                        blue_o  <= byte_i;
`endif
                        sof_o   <= (col == '0) && (row == '0);
                        eol_o   <= last_col;
                        eof_o   <= last_col && last_row;
                        if (last_col) begin
                            col <= '0;
                            row <= last_row ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_stream_unpacker.sv
// Directed bench for rgb_stream_unpacker on a 4x2 frame.
module tb_rgb_stream_unpacker;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] byte_i = '0;
    logic          byte_valid_i = 1'b0;
    logic          byte_ready_o;
    logic [DW-1:0] red_o, green_o, blue_o;
    logic          done_o, sof_o, eol_o, eof_o, busy_o;

    rgb_stream_unpacker #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .red_o        (red_o),
        .green_o      (green_o),
        .blue_o       (blue_o),
        .done_o       (done_o),
        .sof_o        (sof_o),
        .eol_o        (eol_o),
        .eof_o        (eof_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sof, eol, eof;
        logic [DW-1:0] r, g, b;
    } pix_t;

    pix_t pix_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Every strobe seen on the falling edge is logged for later checks
    always @(negedge clk) begin
        if (done_o) pix_q.push_back({sof_o, eol_o, eof_o, red_o, green_o, blue_o});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] b, input int gap);
        byte_i       = b;
        byte_valid_i = 1'b1;
        tick();
        byte_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        pix_q.delete();
    endtask

    // Expected channels computed from bytes in arrival order
    function automatic logic [DW-1:0] exp_red(input logic [DW-1:0] b0, input logic [DW-1:0] b2);
`ifdef RGB_UNPACK_BGR_ORDER_EN
        return b2;
`else
        return b0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_blue(input logic [DW-1:0] b0, input logic [DW-1:0] b2);
`ifdef RGB_UNPACK_BGR_ORDER_EN
        return b0;
`else
        return b2;
`endif
    endfunction

    task automatic expect_pix(input string tag, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                              input logic [DW-1:0] b2, input logic sof, input logic eol, input logic eof);
        pix_t p;
        if (pix_q.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
            return;
        end
        p = pix_q.pop_front();
        chk({tag, "_r"},   p.r,   exp_red(b0, b2));
        chk({tag, "_g"},   p.g,   b1);
        chk({tag, "_b"},   p.b,   exp_blue(b0, b2));
        chk({tag, "_sof"}, p.sof, sof);
        chk({tag, "_eol"}, p.eol, eol);
        chk({tag, "_eof"}, p.eof, eof);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_done",  done_o, 0);
        chk("rst_busy",  busy_o, 0);
        chk("rst_ready", byte_ready_o, 0);
        chk("rst_rgb",   {red_o, green_o, blue_o}, 0);
        do_reset();

        // ---- basic pixel, direct timing check ----
        pulse_start();
        chk("basic_busy",  busy_o, 1);
        chk("basic_ready", byte_ready_o, 1);
        put(8'h10, 0);
        put(8'h20, 0);
        chk("basic_no_early_done", done_o, 0);
        put(8'h30, 0);
        chk("basic_done", done_o, 1);
        chk("basic_r",    red_o,   exp_red(8'h10, 8'h30));
        chk("basic_g",    green_o, 8'h20);
        chk("basic_b",    blue_o,  exp_blue(8'h10, 8'h30));
        chk("basic_sof",  sof_o, 1);
        chk("basic_eol",  eol_o, 0);
        tick();
        chk("basic_done_drop", done_o, 0);
        chk("basic_zero", {red_o, green_o, blue_o, sof_o, eol_o, eof_o}, 0);

        // ---- gapped full frame ----
        do_reset();
        pulse_start();
        for (int i = 0; i < 24; i++) begin
            put(DW'(i + 1), (i == 23) ? 0 : int'($urandom_range(0, 2)));
        end
        chk("frame_last_done", done_o, 1);
        chk("frame_last_eof",  eof_o, 1);
        chk("frame_busy_fall", busy_o, 0);
        chk("frame_ready_fall", byte_ready_o, 0);
        put(8'h99, 3);
        put(8'h9A, 0);
        put(8'h9B, 3);
        chk("frame_count", pix_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            expect_pix($sformatf("frame_px%0d", k), DW'(3*k + 1), DW'(3*k + 2), DW'(3*k + 3),
                       k == 0, (k == 3) || (k == 7), k == 7);
        end

        // ---- bytes in IDLE ignored, including the one on the start cycle ----
        do_reset();
        chk("idle_ready", byte_ready_o, 0);
        put(8'hAA, 0);
        put(8'hBB, 0);
        put(8'hCC, 2);
        chk("idle_no_pix", pix_q.size(), 0);
        byte_i       = 8'hEE;
        byte_valid_i = 1'b1;
        pulse_start();
        byte_valid_i = 1'b0;
        put(8'h01, 0);
        put(8'h02, 1);
        put(8'h03, 2);
        chk("idle_count", pix_q.size(), 1);
        expect_pix("idle_px", 8'h01, 8'h02, 8'h03, 1, 0, 0);

        // ---- restart mid-pixel ----
        do_reset();
        pulse_start();
        for (int i = 0; i < 15; i++) put(DW'(8'h40 + i), 0);
        put(8'h60, 0);
        put(8'h61, 0);
        byte_i       = 8'h62;       // dropped: same cycle as the restart
        byte_valid_i = 1'b1;
        pulse_start();
        byte_valid_i = 1'b0;
        chk("restart_busy", busy_o, 1);
        put(8'h07, 0);
        put(8'h08, 0);
        put(8'h09, 2);
        chk("restart_count", pix_q.size(), 6);
        expect_pix("restart_px0", 8'h40, 8'h41, 8'h42, 1, 0, 0);
        for (int k = 1; k < 5; k++) void'(pix_q.pop_front());
        expect_pix("restart_px_new", 8'h07, 8'h08, 8'h09, 1, 0, 0);

        // ---- async reset between edges ----
        do_reset();
        pulse_start();
        put(8'h10, 0);
        put(8'h20, 0);
        byte_i       = 8'h30;
        byte_valid_i = 1'b1;
        tick();                 // done_o now high
        byte_i       = 8'h40;   // start of next pixel
        #2;
        rst = 1'b0;
        #1;
        chk("arst_done", done_o, 0);
        chk("arst_rgb",  {red_o, green_o, blue_o}, 0);
        chk("arst_busy", busy_o, 0);
        tick();
        byte_valid_i = 1'b0;
        rst = 1'b1;
        pix_q.delete();
        put(8'h51, 0);
        put(8'h52, 0);
        put(8'h53, 2);
        chk("arst_idle_busy", busy_o, 0);
        chk("arst_idle_nopix", pix_q.size(), 0);
        pulse_start();
        put(8'h71, 0);
        put(8'h72, 0);
        put(8'h73, 2);
        expect_pix("arst_after", 8'h71, 8'h72, 8'h73, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
